// File: rtl/rxepktwr_pkg.sv
// Shared definitions for the receive-packet writer.
// State encodings are fixed so that debug tooling can decode o_state directly.
package rxepktwr_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RECV = 2'b01,
        OVFL = 2'b10
    } state_t;

endpackage

// File: rtl/rxepktwr.sv
// Receive-packet writer: packs nibble/byte units into DW-bit words and issues
// word writes to the packet buffer, tracking byte length, end and overflow.
module rxepktwr
    import rxepktwr_pkg::*;
#(
    parameter int AW     = 12,
    parameter int DW     = 32,
    parameter int IW     = 4,
    parameter int BIGEND = 1
) (
    input  logic                        i_clk,
    input  logic                        i_reset_n,
    input  logic                        i_ce,
    input  logic                        i_cancel,
    input  logic                        i_v,
    input  logic [IW-1:0]               i_d,
    output logic                        o_v,
    output logic [AW-1:0]               o_addr,
    output logic [DW-1:0]               o_data,
    output logic [DW/8-1:0]             o_sel,
    output logic [AW+$clog2(DW/8):0]    o_len,
    output logic                        o_done,
    output logic                        o_overflow,
    output logic [1:0]                  o_state
);

    localparam int UPW = DW / IW;
    localparam int LGU = $clog2(UPW);
    localparam int BPW = DW / 8;
    localparam int LGB = $clog2(BPW);
    localparam int LW  = AW + LGB + 1;
    localparam int CW  = AW + LGU;
    // Units per byte is 2 for nibbles, 1 for bytes; NSH is its log2.
    localparam int NSH = (IW == 4) ? 1 : 0;

    localparam logic [CW-1:0] UMAX    = '1;
    localparam logic [CW:0]   ONE_U   = (CW+1)'(1);
    localparam logic [LW-1:0] LEN_MAX = LW'(BPW * (2 ** AW));

    state_t          state;
    logic [CW-1:0]   ucnt;
    logic            full;
    logic            wr;
    logic [DW-1:0]   data_nx;
    logic [BPW-1:0]  sel_nx;
    logic [LW-1:0]   len_nx;
    logic [CW:0]     units;
    int              uw;
    int              lane;
    int              slot;

    function automatic int lane_of(input int k);
        lane_of = (BIGEND != 0) ? (BPW - 1 - k) : k;
    endfunction

    assign o_state = state;

    // Once the last word slot has been written, any further unit is an overflow.
    assign wr = i_v && !i_cancel && ((state == IDLE) || ((state == RECV) && !full));

    always_comb begin
        uw      = int'(ucnt[LGU-1:0]);
        lane    = lane_of(uw >> NSH);
        slot    = (lane << NSH) + ((NSH != 0) ? (uw & 1) : 0);
        data_nx = (uw == 0) ? '0 : o_data;
        sel_nx  = (uw == 0) ? '0 : o_sel;
        for (int i = 0; i < UPW; i++) begin
            if (i == slot) data_nx[i*IW +: IW] = i_d;
        end
        for (int i = 0; i < BPW; i++) begin
            if (i == lane) sel_nx[i] = 1'b1;
        end
        units  = {1'b0, ucnt} + ONE_U;
        len_nx = LW'((units + (CW+1)'(NSH)) >> NSH);
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state      <= IDLE;
            ucnt       <= '0;
            full       <= 1'b0;
            o_v        <= 1'b0;
            o_addr     <= '0;
            o_data     <= '0;
            o_sel      <= '0;
            o_len      <= '0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_ce) begin
            o_v    <= wr;
            o_done <= 1'b0;
            if (wr) begin
                o_addr <= ucnt[CW-1:LGU];
                o_data <= data_nx;
                o_sel  <= sel_nx;
                o_len  <= len_nx;
                ucnt   <= ucnt + CW'(1);
                if (ucnt == UMAX) full <= 1'b1;
            end
            if (i_cancel) begin
                state      <= IDLE;
                ucnt       <= '0;
                full       <= 1'b0;
                o_len      <= '0;
                o_overflow <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_v) begin
                            state      <= RECV;
                            o_overflow <= 1'b0;
                        end
                    end
                    RECV: begin
                        if (!i_v) begin
                            o_done <= 1'b1;
                            state  <= IDLE;
                            ucnt   <= '0;
                            full   <= 1'b0;
                        end else if (full) begin
                            o_overflow <= 1'b1;
                            o_len      <= LEN_MAX;
                            state      <= OVFL;
                        end
                    end
                    OVFL: begin
                        if (!i_v) begin
                            o_done <= 1'b1;
                            state  <= IDLE;
                            ucnt   <= '0;
                            full   <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rxepktwr.sv
// Directed bench for rxepktwr: three configurations share one stimulus bus,
// and a monitor mux selects which instance is being checked.
module tb_rxepktwr;
    import rxepktwr_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic ce;
    logic cancel;
    logic v;
    logic [7:0] d;

    always #5 clk = ~clk;

    // A: DW=32 IW=4 BIGEND=1
    logic        a_v, a_done, a_ovf;
    logic [11:0] a_addr;
    logic [31:0] a_data;
    logic [3:0]  a_sel;
    logic [14:0] a_len;
    logic [1:0]  a_state;
    // B: DW=64 IW=8 BIGEND=0
    logic        b_v, b_done, b_ovf;
    logic [11:0] b_addr;
    logic [63:0] b_data;
    logic [7:0]  b_sel;
    logic [15:0] b_len;
    logic [1:0]  b_state;
    // C: AW=2 DW=32 IW=8 BIGEND=1
    logic        c_v, c_done, c_ovf;
    logic [1:0]  c_addr;
    logic [31:0] c_data;
    logic [3:0]  c_sel;
    logic [4:0]  c_len;
    logic [1:0]  c_state;

    rxepktwr #(.AW(12), .DW(32), .IW(4), .BIGEND(1)) u_a (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_cancel(cancel), .i_v(v),
        .i_d(d[3:0]), .o_v(a_v), .o_addr(a_addr), .o_data(a_data), .o_sel(a_sel),
        .o_len(a_len), .o_done(a_done), .o_overflow(a_ovf), .o_state(a_state)
    );

    rxepktwr #(.AW(12), .DW(64), .IW(8), .BIGEND(0)) u_b (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_cancel(cancel), .i_v(v),
        .i_d(d), .o_v(b_v), .o_addr(b_addr), .o_data(b_data), .o_sel(b_sel),
        .o_len(b_len), .o_done(b_done), .o_overflow(b_ovf), .o_state(b_state)
    );

    rxepktwr #(.AW(2), .DW(32), .IW(8), .BIGEND(1)) u_c (
        .i_clk(clk), .i_reset_n(rst_n), .i_ce(ce), .i_cancel(cancel), .i_v(v),
        .i_d(d), .o_v(c_v), .o_addr(c_addr), .o_data(c_data), .o_sel(c_sel),
        .o_len(c_len), .o_done(c_done), .o_overflow(c_ovf), .o_state(c_state)
    );

    int          sel_dut = 0;
    logic        mon_v, mon_done, mon_ovf;
    logic [15:0] mon_addr;
    logic [63:0] mon_data;
    logic [7:0]  mon_sel;
    logic [15:0] mon_len;
    logic [1:0]  mon_state;

    always_comb begin
        mon_v = 1'b0; mon_done = 1'b0; mon_ovf = 1'b0; mon_addr = '0;
        mon_data = '0; mon_sel = '0; mon_len = '0; mon_state = '0;
        case (sel_dut)
            0: begin
                mon_v = a_v; mon_done = a_done; mon_ovf = a_ovf; mon_addr = 16'(a_addr);
                mon_data = 64'(a_data); mon_sel = 8'(a_sel); mon_len = 16'(a_len); mon_state = a_state;
            end
            1: begin
                mon_v = b_v; mon_done = b_done; mon_ovf = b_ovf; mon_addr = 16'(b_addr);
                mon_data = b_data; mon_sel = b_sel; mon_len = b_len; mon_state = b_state;
            end
            default: begin
                mon_v = c_v; mon_done = c_done; mon_ovf = c_ovf; mon_addr = 16'(c_addr);
                mon_data = 64'(c_data); mon_sel = 8'(c_sel); mon_len = 16'(c_len); mon_state = c_state;
            end
        endcase
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [87:0] exp_q[$];

    task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [87:0] pk(input logic [15:0] a, input logic [63:0] dd, input logic [7:0] s);
        return {a, dd, s};
    endfunction

    // One accepted ce cycle; slow mode inserts three ce-low cycles with junk inputs.
    task automatic unit(input logic uv, input logic [7:0] ud, input logic uc, input bit slow);
        if (slow) begin
            for (int i = 0; i < 3; i++) begin
                ce = 1'b0;
                v = 1'($urandom_range(0, 1));
                d = 8'($urandom_range(0, 255));
                cancel = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
        end
        ce = 1'b1; v = uv; d = ud; cancel = uc;
        @(posedge clk); #1;
        ce = 1'b0;
        if (mon_v) begin
            if (exp_q.size() == 0) check("sb_unexp_wr", pk(mon_addr, mon_data, mon_sel), '0);
            else check("sb_write", pk(mon_addr, mon_data, mon_sel), exp_q.pop_front());
        end
    endtask

    task automatic chk_zero(input string tag);
        check({tag, "_data"}, 88'(mon_data), '0);
        check({tag, "_ctl"}, 88'({mon_v, mon_done, mon_ovf, mon_state, mon_sel, mon_len, mon_addr}), '0);
    endtask

    logic [31:0] t1_data[8] = '{32'h01000000, 32'h21000000, 32'h21030000, 32'h21430000,
                                32'h21430500, 32'h21436500, 32'h21436507, 32'h21436587};
    logic [7:0]  t1_sel[8]  = '{8'h08, 8'h08, 8'h0C, 8'h0C, 8'h0E, 8'h0E, 8'h0F, 8'h0F};
    logic [63:0] t3_data[9] = '{64'h11, 64'h1211, 64'h131211, 64'h14131211, 64'h1514131211,
                                64'h161514131211, 64'h17161514131211, 64'h1817161514131211, 64'h19};
    logic [7:0]  t3_sel[9]  = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'h01};
    logic [31:0] t5_data[6] = '{32'h09000000, 32'hA9000000, 32'hA90B0000, 32'hA9CB0000,
                                32'hA9CB0D00, 32'hA9CBED00};
    logic [7:0]  t5_sel[6]  = '{8'h08, 8'h08, 8'h0C, 8'h0C, 8'h0E, 8'h0E};

    logic [31:0] acc;
    logic [7:0]  s;

    initial begin
        rst_n = 1'b0; ce = 1'b0; cancel = 1'b0; v = 1'b0; d = '0;
        #12;
        for (int k = 0; k < 3; k++) begin
            sel_dut = k; #1;
            chk_zero($sformatf("rst%0d", k));
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Full word of nibbles, big-endian.
        sel_dut = 0;
        for (int i = 0; i < 8; i++) exp_q.push_back(pk(16'h0, 64'(t1_data[i]), t1_sel[i]));
        for (int i = 0; i < 8; i++) unit(1'b1, 8'(i + 1), 1'b0, 1'b0);
        unit(1'b0, 8'h0, 1'b0, 1'b0);
        check("t1_end", 88'({mon_v, mon_done, mon_state, mon_len}), 88'({1'b0, 1'b1, IDLE, 16'd4}));
        unit(1'b0, 8'h0, 1'b0, 1'b0);
        check("t1_hold", 88'({mon_done, mon_len}), 88'({1'b0, 16'd4}));
        check("t1_sb_left", 88'(exp_q.size()), '0);

        // Partial word: five nibbles.
        for (int i = 0; i < 5; i++) exp_q.push_back(pk(16'h0, 64'(t1_data[i]), t1_sel[i]));
        for (int i = 0; i < 5; i++) unit(1'b1, 8'(i + 1), 1'b0, 1'b0);
        unit(1'b0, 8'h0, 1'b0, 1'b0);
        check("t2_end", 88'({mon_done, mon_len}), 88'({1'b1, 16'd3}));
        check("t2_sb_left", 88'(exp_q.size()), '0);

        // 64-bit little-endian bytes spilling into a second word.
        sel_dut = 1;
        for (int i = 0; i < 9; i++) exp_q.push_back(pk(16'(i / 8), t3_data[i], t3_sel[i]));
        for (int i = 0; i < 9; i++) unit(1'b1, 8'(8'h11 + i), 1'b0, 1'b0);
        unit(1'b0, 8'h0, 1'b0, 1'b0);
        check("t3_end", 88'({mon_done, mon_ovf, mon_len}), 88'({1'b1, 1'b0, 16'd9}));
        check("t3_sb_left", 88'(exp_q.size()), '0);

        // Overflow of a 4-word buffer with a 20-byte packet.
        sel_dut = 2;
        acc = '0; s = '0;
        for (int i = 0; i < 16; i++) begin
            if (i % 4 == 0) begin acc = '0; s = '0; end
            acc[31 - 8 * (i % 4) -: 8] = 8'(i + 1);
            s[3 - (i % 4)] = 1'b1;
            exp_q.push_back(pk(16'(i / 4), 64'(acc), s));
        end
        for (int i = 0; i < 20; i++) begin
            unit(1'b1, 8'(i + 1), 1'b0, 1'b0);
            if (i == 15) check("t4_len16", 88'(mon_len), 88'(16));
            if (i == 16) check("t4_ovf", 88'({mon_ovf, mon_state}), 88'({1'b1, OVFL}));
        end
        check("t4_sb_left", 88'(exp_q.size()), '0);
        unit(1'b0, 8'h0, 1'b0, 1'b0);
        check("t4_end", 88'({mon_done, mon_ovf, mon_len}), 88'({1'b1, 1'b1, 16'd16}));
        unit(1'b0, 8'h0, 1'b0, 1'b0);
        check("t4_sticky", 88'({mon_done, mon_ovf}), 88'({1'b0, 1'b1}));
        exp_q.push_back(pk(16'h0, 64'h00000000AA000000, 8'h08));
        unit(1'b1, 8'hAA, 1'b0, 1'b0);
        check("t4_newpkt", 88'({mon_ovf, mon_len}), 88'({1'b0, 16'd1}));
        unit(1'b0, 8'h0, 1'b0, 1'b0);
        check("t4_sb_left2", 88'(exp_q.size()), '0);

        // Cancel after six nibbles, then a fresh packet.
        sel_dut = 0;
        for (int i = 0; i < 6; i++) exp_q.push_back(pk(16'h0, 64'(t5_data[i]), t5_sel[i]));
        for (int i = 0; i < 6; i++) unit(1'b1, 8'(9 + i), 1'b0, 1'b0);
        unit(1'b1, 8'hF, 1'b1, 1'b0);
        check("t5_cancel", 88'({mon_v, mon_done, mon_ovf, mon_state, mon_len}),
              88'({1'b0, 1'b0, 1'b0, IDLE, 16'd0}));
        unit(1'b0, 8'h0, 1'b0, 1'b0);
        check("t5_nodone", 88'(mon_done), '0);
        exp_q.push_back(pk(16'h0, 64'h0000000003000000, 8'h08));
        unit(1'b1, 8'h3, 1'b0, 1'b0);
        unit(1'b0, 8'h0, 1'b0, 1'b0);
        check("t5_next", 88'({mon_done, mon_len}), 88'({1'b1, 16'd1}));
        check("t5_sb_left", 88'(exp_q.size()), '0);

        // Sparse ce with junk inputs during ce-low cycles.
        for (int i = 0; i < 8; i++) exp_q.push_back(pk(16'h0, 64'(t1_data[i]), t1_sel[i]));
        for (int i = 0; i < 8; i++) unit(1'b1, 8'(i + 1), 1'b0, 1'b1);
        unit(1'b0, 8'h0, 1'b0, 1'b1);
        check("t6_end", 88'({mon_done, mon_len}), 88'({1'b1, 16'd4}));
        check("t6_sb_left", 88'(exp_q.size()), '0);

        // Asynchronous reset mid-packet.
        for (int i = 0; i < 3; i++) exp_q.push_back(pk(16'h0, 64'(t1_data[i]), t1_sel[i]));
        for (int i = 0; i < 3; i++) unit(1'b1, 8'(i + 1), 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk_zero("t7_rst");
        #2 rst_n = 1'b1;
        unit(1'b0, 8'h0, 1'b0, 1'b0);
        check("t7_nodone", 88'({mon_done, mon_state}), 88'({1'b0, IDLE}));
        exp_q.push_back(pk(16'h0, 64'h0000000005000000, 8'h08));
        unit(1'b1, 8'h5, 1'b0, 1'b0);
        unit(1'b0, 8'h0, 1'b0, 1'b0);
        check("t7_next", 88'({mon_done, mon_len}), 88'({1'b1, 16'd1}));
        check("t7_sb_left", 88'(exp_q.size()), '0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/rxepktwr.md
# rxepktwr

Parametrised receive-packet writer for the Ethernet RX filter chain. It packs an in-order stream of nibbles or bytes into DW-bit words and issues word writes to the packet buffer RAM. It reports byte length, end-of-packet and overflow. It is the successor of the fixed 32-bit nibble writer and adds configurable unit/word widths, byte order, byte lane enables, a done strobe, and buffer-capacity protection.

## Interface
- AW, 12: word-address width; buffer holds 2^AW words.
- DW, 32: output word width; one of 32 or 64.
- IW, 4: input unit width; 4 (MII nibbles) or 8 (bytes).
- BIGEND, 1: 1 puts packet byte 0 in the word MSB; 0 puts it in the word LSB.
- Derived, not overridable:
  - UPW = DW/IW, LGU = log2(UPW).
  - BPW = DW/8, LGB = log2(BPW).
  - LW = AW+LGB+1.
- i_clk  in  1  system clock, all logic on rising edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_ce  in  1  unit strobe; nothing advances and all outputs hold while low.
- i_cancel  in  1  abort the current packet (qualified by i_ce).
- i_v  in  1  unit valid; high for the contiguous duration of a packet.
- i_d  in  IW  data unit; nibbles arrive low-half first within each byte.
- o_v  out  1  word write strobe.
- o_addr  out  AW  word address.
- o_data  out  DW  full word to write; not-yet-received lanes are zero.
- o_sel  out  BPW  byte lanes holding received data in the current word, cumulative.
- o_len  out  LW  packet length in bytes, rounded up; holds after the packet ends.
- o_done  out  1  one-ce-cycle end-of-packet strobe.
- o_overflow  out  1  packet exceeded buffer capacity; sticky until the next packet starts or a cancel.

## Operation
- A unit counter ucnt of AW+LGU bits gives the current unit index within the packet.
- States:
  - IDLE → RECV on the first i_v with i_ce; ucnt=0, o_len and o_overflow cleared.
  - RECV:
    - Each i_v unit is written at o_addr = ucnt[AW+LGU-1:LGU], then ucnt increments.
    - When i_v falls: o_done pulses, state → IDLE, ucnt → 0.
    - When ucnt would pass 2^(AW+LGU)-1: o_overflow=1, state → OVFL.
  - OVFL:
    - Units are discarded; o_v=0; o_len saturates at 2^AW·BPW.
    - When i_v falls: o_done pulses, state → IDLE.
- Lane placement for packet byte b, with lane k = b mod BPW:
  - BIGEND=1: bits [DW-1-8k -: 8].
  - BIGEND=0: bits [8k +: 8].
  - IW=4: the first nibble fills bits [3:0] of the lane, the second fills [7:4]. The high half stays 0 until it arrives.
- On the first unit of a word, all other lanes are cleared. Later units preserve previously written lanes.
- o_sel:
  - Bit k is set once any nibble of lane k has been written in the current word.
  - All lanes are clear on the first unit of a word except the current lane.
- o_len = ceil(units·IW/8), updated with every accepted unit.
- i_cancel:
  - Takes priority over everything: state → IDLE, o_v=0, ucnt=0, o_len=0, o_overflow=0.
  - No o_done is issued.
  - If i_cancel and i_v are high together, the unit is dropped.
- Simultaneous end and overflow on the same unit: that unit is dropped, o_overflow sets, and o_done follows on the next ce cycle.

## Timing
- Every output is reset to 0 by i_reset_n low, asynchronously, in any state. Reset mid-packet discards the packet with no o_done.
- Latency: one i_ce cycle from the unit's arrival to o_v/o_addr/o_data/o_sel/o_len.
- o_v mirrors accepted i_v one ce cycle later.
- o_done is asserted on the first ce cycle with i_v low after a packet, in the same cycle that o_v drops.
- o_len is final when o_done is high and is stable thereafter.
- A new packet may start on the ce cycle immediately after the i_v-low cycle. Back-to-back packets need at least one idle unit.

## Structure
- One module, no sub-module.
- A shared package/header holds the state encodings: IDLE=2'b00, RECV=2'b01, OVFL=2'b10.
- The lane-index function (BIGEND mapping) is a local function inside the module.

## Test plan
- DW=32, IW=4, BIGEND=1, nibbles 1,2,3,4,5,6,7,8:
  - Writes go to addr 0.
  - The final write has o_data=0x21436587, o_sel=4'b1111.
  - o_done follows, o_len=4.
- Same config, 5 nibbles 1..5:
  - The last write has o_data=0x21430500, o_sel=4'b1110.
  - o_len=3.
- DW=64, IW=8, BIGEND=0, bytes 0x11..0x19:
  - Addr 0 gets 0x1817161514131211.
  - Addr 1 gets 0x19 with o_sel=8'h01.
  - o_len=9.
- AW=2, DW=32, IW=8, 20-byte packet:
  - Addrs 0..3 are written.
  - o_overflow=1 after byte 16, with no further o_v.
  - o_len=16; o_done pulses after i_v falls.
- i_cancel mid-packet (after 6 nibbles): o_v drops, o_len=0, no o_done. The next packet starts at addr 0.
- i_ce toggling 1-of-4 during a packet gives output identical to i_ce=1. i_reset_n low mid-packet clears all outputs immediately.
